// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared constants, state codes and opcode classifier for mc_ctrl_fsm
// Contents: opcode values, addressing-mode constant, FSM state encodings,
// ALU_OP / RD_SEL codes, op_kind_e and classify() helper.
package mc_ctrl_pkg;

  // Opcode values (4-bit; wider opcode fields are compared zero-extended)
  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWAP = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [3:0] AM_IMM  = 4'd8;

  // FSM state encodings
  localparam logic [3:0] S_RST0    = 4'd0;
  localparam logic [3:0] S_RST1    = 4'd1;
  localparam logic [3:0] S_FETCH   = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_EXECUTE = 4'd4;
  localparam logic [3:0] S_MEM     = 4'd5;
  localparam logic [3:0] S_WB      = 4'd6;
  localparam logic [3:0] S_WB2     = 4'd7;
  localparam logic [3:0] S_HALT    = 4'd8;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_IMM  = 2'b01;
  localparam logic [1:0] ALUOP_PASS = 2'b10;

  localparam logic [1:0] RDSEL_REG  = 2'd0;
  localparam logic [1:0] RDSEL_IMM  = 2'd1;
  localparam logic [1:0] RDSEL_SWAP = 2'd2;

  typedef enum logic [3:0] {
    K_NOOP, K_LOD, K_STR, K_SWAP, K_BRA, K_BRR, K_BNE, K_ALU, K_HLT
  } op_kind_e;

  // ext_zero is low when any opcode bit above bit 3 is set; such opcodes
  // are undefined and fall back to NOOP like every other unknown value.
  function automatic op_kind_e classify(input logic [3:0] op, input logic ext_zero);
    op_kind_e k;
    k = K_NOOP;
    if (ext_zero) begin
      case (op)
        OP_LOD:  k = K_LOD;
        OP_STR:  k = K_STR;
        OP_SWAP: k = K_SWAP;
        OP_BRA:  k = K_BRA;
        OP_BRR:  k = K_BRR;
        OP_BNE:  k = K_BNE;
        OP_ALU:  k = K_ALU;
        OP_HLT:  k = K_HLT;
        default: k = K_NOOP;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_br_eval.sv
// rtl/mc_ctrl_fsm_br_eval.sv - combinational branch taken decision
// Ports: kind (decoded opcode), mask (mode/mask field), stat (ALU flags),
// taken (1 when the branch should redirect the PC).
module mc_ctrl_br_eval
  import mc_ctrl_pkg::*;
#(
  parameter int MMW = 4,
  parameter int STW = 4
) (
  input  op_kind_e         kind,
  input  logic [MMW-1:0]   mask,
  input  logic [STW-1:0]   stat,
  output logic             taken
);

  // Only the overlapping low bits of mask and status take part.
  localparam int BW = (MMW < STW) ? MMW : STW;

  logic hit;
  assign hit = |(mask[BW-1:0] & stat[BW-1:0]);

  always_comb begin
    taken = 1'b0;
    case (kind)
      K_BRA, K_BRR: taken = hit;
      K_BNE:        taken = ~hit;
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle CPU control FSM (FETCH/DECODE/EXECUTE/MEM/WB/WB2/HALT)
// Optional build macro: MC_CTRL_DM_TIMEOUT_EN (data-memory ack timeout -> HALT + ERR).
// Inputs : CLK, RST (sync, active high), OPCODE, MM, STAT, DM_ACK.
// Outputs: PC_RST, PC_WRITE, PC_SEL, BR_SEL, RF_WE, WB_SEL, RD_SEL, ALU_OP,
//          MM_SEL, DM_REQ, DM_WE, SWAP_SEL, HALTED, ERR, STATE (debug).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int MMW          = 4,
  parameter int STW          = 4,
  parameter int DM_TO_CYCLES = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] OPCODE,
  input  logic [MMW-1:0] MM,
  input  logic [STW-1:0] STAT,
  input  logic           DM_ACK,
  output logic           PC_RST,
  output logic           PC_WRITE,
  output logic           PC_SEL,
  output logic           BR_SEL,
  output logic           RF_WE,
  output logic           WB_SEL,
  output logic [1:0]     RD_SEL,
  output logic [1:0]     ALU_OP,
  output logic           MM_SEL,
  output logic           DM_REQ,
  output logic           DM_WE,
  output logic           SWAP_SEL,
  output logic           HALTED,
  output logic           ERR,
  output logic [3:0]     STATE
);

  logic [3:0]     state, state_nxt;
  logic [OPW-1:0] ir_op;
  logic [MMW-1:0] ir_mm;
  logic           taken, taken_q;
  logic           op_ext_zero;
  logic           mm_imm;
  op_kind_e       kind;

  generate
    if (OPW > 4) begin : g_opx
      assign op_ext_zero = ~|ir_op[OPW-1:4];
    end else begin : g_op4
      assign op_ext_zero = 1'b1;
    end
  endgenerate

  assign kind   = classify(ir_op[3:0], op_ext_zero);
  assign mm_imm = (ir_mm == MMW'(AM_IMM));

  // STAT is sampled in DECODE so the EXECUTE outputs depend on registers only.
  mc_ctrl_br_eval #(
    .MMW (MMW),
    .STW (STW)
  ) u_br_eval (
    .kind  (kind),
    .mask  (ir_mm),
    .stat  (STAT),
    .taken (taken)
  );

`ifdef MC_CTRL_DM_TIMEOUT_EN
  localparam int CW = $clog2(DM_TO_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  logic          err_q;

  // to_cnt counts completed ack-less MEM cycles; the last allowed one is DM_TO_CYCLES-1.
  assign to_hit = (to_cnt == CW'(DM_TO_CYCLES - 1));
  assign ERR    = err_q;
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (DM_TO_CYCLES > 0);
  assign ERR           = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_RST0;
      ir_op   <= '0;
      ir_mm   <= '0;
      taken_q <= 1'b0;
`ifdef MC_CTRL_DM_TIMEOUT_EN
      to_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir_op <= OPCODE;
        ir_mm <= MM;
      end
      if (state == S_DECODE) begin
        taken_q <= taken;
      end
`ifdef MC_CTRL_DM_TIMEOUT_EN
      // Held at zero outside MEM, so every MEM visit starts a fresh count.
      if (state != S_MEM) begin
        to_cnt <= '0;
      end else if (!DM_ACK) begin
        to_cnt <= to_cnt + CW'(1);
        if (to_hit) begin
          err_q <= 1'b1;
        end
      end
`endif
    end
  end

  always_comb begin
    state_nxt = S_RST0;
    case (state)
      S_RST0:   state_nxt = S_RST1;
      S_RST1:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (kind == K_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        case (kind)
          K_LOD, K_STR:  state_nxt = S_MEM;
          K_ALU, K_SWAP: state_nxt = S_WB;
          default:       state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (DM_ACK) begin
          state_nxt = (kind == K_STR) ? S_FETCH : S_WB;
        end else begin
          state_nxt = S_MEM;
`ifdef MC_CTRL_DM_TIMEOUT_EN
          if (to_hit) begin
            state_nxt = S_HALT;
          end
`endif
        end
      end
      S_WB:     state_nxt = (kind == K_SWAP) ? S_WB2 : S_FETCH;
      S_WB2:    state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RST0;
    endcase
  end

  always_comb begin
    PC_RST   = 1'b0;
    PC_WRITE = 1'b0;
    PC_SEL   = 1'b0;
    BR_SEL   = 1'b0;
    RF_WE    = 1'b0;
    WB_SEL   = 1'b0;
    RD_SEL   = RDSEL_REG;
    ALU_OP   = ALUOP_ADD;
    MM_SEL   = 1'b0;
    DM_REQ   = 1'b0;
    DM_WE    = 1'b0;
    SWAP_SEL = 1'b0;
    HALTED   = 1'b0;
    STATE    = state;
    case (state)
      S_RST0, S_RST1: PC_RST = 1'b1;
      S_FETCH:        PC_WRITE = 1'b1;
      S_DECODE: begin
        if (kind == K_SWAP) begin
          RD_SEL = RDSEL_SWAP;
        end else if ((kind == K_ALU && mm_imm) || kind == K_LOD) begin
          RD_SEL = RDSEL_IMM;
        end
      end
      S_EXECUTE: begin
        case (kind)
          K_ALU: ALU_OP = mm_imm ? ALUOP_IMM : ALUOP_ADD;
          K_LOD, K_STR: begin
            // Immediate mode addresses by imm alone; otherwise imm+rs via the index path.
            if (mm_imm) begin
              ALU_OP = ALUOP_ADD;
              MM_SEL = 1'b1;
            end else begin
              ALU_OP = ALUOP_IMM;
            end
          end
          K_BRA, K_BRR, K_BNE: begin
            ALU_OP = ALUOP_PASS;
            if (taken_q) begin
              PC_WRITE = 1'b1;
              PC_SEL   = 1'b1;
              BR_SEL   = (kind != K_BRR);
            end
          end
          K_SWAP:  ALU_OP = ALUOP_PASS;
          default: ALU_OP = ALUOP_ADD;
        endcase
      end
      S_MEM: begin
        DM_REQ = 1'b1;
        DM_WE  = (kind == K_STR);
      end
      S_WB: begin
        RF_WE  = 1'b1;
        WB_SEL = (kind == K_LOD);
      end
      S_WB2: begin
        RF_WE    = 1'b1;
        SWAP_SEL = 1'b1;
        RD_SEL   = RDSEL_SWAP;
      end
      S_HALT:  HALTED = 1'b1;
      default: PC_RST = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed scoreboard bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] OPCODE, MM, STAT;
  logic       DM_ACK;
  logic       PC_RST, PC_WRITE, PC_SEL, BR_SEL, RF_WE, WB_SEL;
  logic [1:0] RD_SEL, ALU_OP;
  logic       MM_SEL, DM_REQ, DM_WE, SWAP_SEL, HALTED, ERR;
  logic [3:0] STATE;

  mc_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .MM(MM), .STAT(STAT), .DM_ACK(DM_ACK),
    .PC_RST(PC_RST), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL), .BR_SEL(BR_SEL),
    .RF_WE(RF_WE), .WB_SEL(WB_SEL), .RD_SEL(RD_SEL), .ALU_OP(ALU_OP),
    .MM_SEL(MM_SEL), .DM_REQ(DM_REQ), .DM_WE(DM_WE), .SWAP_SEL(SWAP_SEL),
    .HALTED(HALTED), .ERR(ERR), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  localparam logic [19:0] PCRST = 20'h80000, PCW   = 20'h40000, PCSEL = 20'h20000;
  localparam logic [19:0] BRSEL = 20'h10000, RFWE  = 20'h08000, WBSEL = 20'h04000;
  localparam logic [19:0] MMSEL = 20'h00200, DMREQ = 20'h00100, DMWE  = 20'h00080;
  localparam logic [19:0] SWSEL = 20'h00040, HLTD  = 20'h00020, ERRB  = 20'h00010;
  localparam logic [19:0] T_RST0 = 20'd0, T_RST1 = 20'd1, T_FETCH = 20'd2, T_DEC = 20'd3;
  localparam logic [19:0] T_EXE = 20'd4, T_MEM = 20'd5, T_WB = 20'd6, T_WB2 = 20'd7, T_HALT = 20'd8;

  logic [19:0] obs;
  assign obs = {PC_RST, PC_WRITE, PC_SEL, BR_SEL, RF_WE, WB_SEL, RD_SEL, ALU_OP,
                MM_SEL, DM_REQ, DM_WE, SWAP_SEL, HALTED, ERR, STATE};

  logic [19:0] exp_q[$];
  bit          ack_q[$];
  int          nvec = 0;
  int          errs = 0;

  function automatic logic [19:0] rd(input int v);
    return 20'(v) << 12;
  endfunction

  function automatic logic [19:0] alu(input int v);
    return 20'(v) << 10;
  endfunction

  task automatic push(input logic [19:0] e, input bit a);
    exp_q.push_back(e);
    ack_q.push_back(a);
  endtask

  // Called at a negedge: compares the current cycle, drives DM_ACK for it, advances.
  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      logic [19:0] e;
      bit          a;
      e = exp_q.pop_front();
      a = ack_q.pop_front();
      nvec++;
      assert (obs === e) else begin
        errs++;
        $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, e);
      end
      DM_ACK = a;
      i++;
      @(negedge CLK);
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    DM_ACK = 1'b0;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    push(PCRST | T_RST0, 1'b0);
    push(PCRST | T_RST1, 1'b0);
    drain("reset");
  endtask

  task automatic set_in(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st);
    OPCODE = op;
    MM     = mm;
    STAT   = st;
  endtask

  task automatic fd(input int rdv, input bit a);
    push(PCW | T_FETCH, a);
    push(T_DEC | rd(rdv), a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; DM_ACK = 1'b0;
    set_in(4'd0, 4'd0, 4'd0);
    do_reset(3);

    set_in(4'd8, 4'd8, 4'd0);
    fd(1, 0); push(T_EXE | alu(1), 0); push(T_WB | RFWE, 0);
    drain("alu_imm");

    set_in(4'd8, 4'd0, 4'd0);
    fd(0, 1); push(T_EXE | alu(0), 1); push(T_WB | RFWE, 1);
    drain("alu_reg_stray_ack");

    set_in(4'd5, 4'd1, 4'd1);
    fd(0, 0); push(T_EXE | alu(2) | PCW | PCSEL, 0);
    drain("brr_taken");

    set_in(4'd5, 4'd1, 4'd0);
    fd(0, 0); push(T_EXE | alu(2), 0);
    drain("brr_not_taken");

    set_in(4'd4, 4'd1, 4'd1);
    fd(0, 0); push(T_EXE | alu(2) | PCW | PCSEL | BRSEL, 0);
    drain("bra_taken");

    set_in(4'd4, 4'd2, 4'd1);
    fd(0, 0); push(T_EXE | alu(2), 0);
    drain("bra_mask_miss");

    set_in(4'd6, 4'd1, 4'd0);
    fd(0, 0); push(T_EXE | alu(2) | PCW | PCSEL | BRSEL, 0);
    drain("bne_taken");

    set_in(4'd6, 4'd1, 4'd1);
    fd(0, 0); push(T_EXE | alu(2), 0);
    drain("bne_not_taken");

    set_in(4'd0, 4'd8, 4'd0);
    fd(0, 0); push(T_EXE, 0);
    drain("noop");

    set_in(4'd11, 4'd8, 4'd0);
    fd(0, 0); push(T_EXE, 0);
    drain("undef_op");

    set_in(4'd1, 4'd0, 4'd0);
    fd(1, 0); push(T_EXE | alu(1), 0);
    push(T_MEM | DMREQ, 0); push(T_MEM | DMREQ, 0); push(T_MEM | DMREQ, 0); push(T_MEM | DMREQ, 1);
    push(T_WB | RFWE | WBSEL, 0);
    drain("lod_wait3");

    set_in(4'd2, 4'd8, 4'd0);
    fd(0, 0); push(T_EXE | MMSEL, 0);
    for (int k = 0; k < 4; k++) push(T_MEM | DMREQ | DMWE, (k == 3));
    drain("str_wait3");

    set_in(4'd1, 4'd8, 4'd0);
    fd(1, 1); push(T_EXE | MMSEL, 1); push(T_MEM | DMREQ, 1); push(T_WB | RFWE | WBSEL, 0);
    drain("lod_zero_wait");

    set_in(4'd3, 4'd0, 4'd0);
    fd(2, 0); push(T_EXE | alu(2), 0); push(T_WB | RFWE, 0);
    push(T_WB2 | RFWE | SWSEL | rd(2), 0);
    drain("swap");

    set_in(4'd1, 4'd0, 4'd0);
    fd(1, 0); push(T_EXE | alu(1), 0); push(T_MEM | DMREQ, 0); push(T_MEM | DMREQ, 0);
    drain("lod_pre_reset");
    do_reset(1);

    set_in(4'd1, 4'd0, 4'd0);
    fd(1, 0); push(T_EXE | alu(1), 0);
`ifdef MC_CTRL_DM_TIMEOUT_EN
    for (int k = 0; k < 16; k++) push(T_MEM | DMREQ, 0);
    push(T_HALT | HLTD | ERRB, 0); push(T_HALT | HLTD | ERRB, 0);
    drain("dm_timeout");
`else
    for (int k = 0; k < 20; k++) push(T_MEM | DMREQ, 0);
    drain("dm_wait_forever");
`endif
    do_reset(1);

    set_in(4'd15, 4'd0, 4'd0);
    fd(0, 0);
    for (int k = 0; k < 20; k++) push(T_HALT | HLTD, k[0]);
    drain("halt");
    do_reset(1);

    set_in(4'd0, 4'd0, 4'd0);
    fd(0, 0); push(T_EXE, 0); push(PCW | T_FETCH, 0);
    drain("post_halt_noop");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
